// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Registered view of who owns the shared mux.
    typedef struct packed {
        logic [N_REQ-1:0] sel;
        logic             valid;
        logic [IDX_W-1:0] owner;
    } grant_t;

    // One-hot vector with bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Circular first-set-bit finder: scans mask from start upward, wrapping 7->0.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the far end back toward start so the nearest set bit wins last.
    always_comb begin
        logic [IDX_W-1:0] pos;
        idx = '0;
        any = |mask;
        pos = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = start + IDX_W'(k);
            if (mask[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner selection for the shared 8:1 one-hot mux, with tenure preemption.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] sel,
    output logic             valid,
    output logic [IDX_W-1:0] owner
);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] HOLD_LIM = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic          PREEMPT  = (MAX_HOLD != 0);

    // Tenure counter must be able to reach the hold limit.
    if ((64'(1) << CW) <= 64'(MAX_HOLD)) begin : g_bad_cw
        $error("mux8_rr_arbiter: CW too narrow for MAX_HOLD");
    end

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]    cnt;
    grant_t           grant;

    logic [N_REQ-1:0] pre_mask;
    logic [IDX_W-1:0] norm_idx;
    logic             norm_any;
    logic [IDX_W-1:0] pre_idx;
    logic             pre_any;
    logic             owner_req;
    logic             tenure_up;

    // Candidates other than the current owner, used for forced rotation.
    assign pre_mask  = req & ~grant.sel;
    assign owner_req = req[grant.owner];
    // Saturated counter stays at or above the limit, so a late newcomer still preempts.
    assign tenure_up = PREEMPT && (cnt >= HOLD_LIM);

    rr_pick8 u_pick_norm (
        .mask  (req),
        .start (ptr),
        .idx   (norm_idx),
        .any   (norm_any)
    );

    rr_pick8 u_pick_pre (
        .mask  (pre_mask),
        .start (ptr),
        .idx   (pre_idx),
        .any   (pre_any)
    );

    // Arbitration FSM; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant.sel   <= '0;
            grant.valid <= 1'b0;
            grant.owner <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (norm_any) begin
                        grant.sel   <= onehot(norm_idx);
                        grant.valid <= 1'b1;
                        grant.owner <= norm_idx;
                        ptr         <= norm_idx + IDX_W'(1);
                        cnt         <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_req) begin
                        if (norm_any) begin
                            // Direct hand-off, no dead cycle on the mux.
                            grant.sel   <= onehot(norm_idx);
                            grant.owner <= norm_idx;
                            ptr         <= norm_idx + IDX_W'(1);
                            cnt         <= '0;
                        end else begin
                            grant.sel   <= '0;
                            grant.valid <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end else if (tenure_up && pre_any) begin
                        // Forced rotation; the old owner keeps requesting and waits its turn.
                        grant.sel   <= onehot(pre_idx);
                        grant.owner <= pre_idx;
                        ptr         <= pre_idx + IDX_W'(1);
                        cnt         <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel   = grant.sel;
    assign valid = grant.valid;
    assign owner = grant.owner;

endmodule
